bus_arbiter_multi: RTL
======================

// Module: bus_arbiter_multi
// PURPOSE
//  68000-style three-wire (BR/BG/BGACK) bus-mastership arbiter for the accelerator board, NREQ-way successor of the single-master arbiter.
//  Requests the host bus on behalf of NREQ local masters, holds it via BGACK and grants it to one local master at a time.
//  Hands mastership between local masters without releasing the host bus; returns the bus when idle or when the host re-requests.
//  Adds fixed-priority or round-robin selection, and a grant-wait timeout.
// PARAMETERS
//  NREQ      2    number of local requesters (1..8)
//  RR_MODE   0    0 = fixed priority (lowest index wins), 1 = round-robin
//  TMO_W     8    width of the grant-wait timer
//  TMO_MAX   255  REQ cycles without host BG before abandoning the request (must be < 2**TMO_W)
// PORTS
//  CLOCK     in   1     board clock; all logic on posedge
//  RST       in   1     synchronous, active-high reset
//  ENABLE    in   1     arbiter enabled; low forces IDLE and releases all drives
//  REQ       in   NREQ  local bus requests, active high, level-held until done
//  _XAS      in   1     host address strobe, active low
//  _XBG      in   1     host bus grant, active low
//  _XBR_IN   in   1     sampled host bus-request line, active low
//  _XBGK_IN  in   1     sampled host bus-grant-ack line, active low
//  XBR_OE    out  1     1 = drive open-drain _XBR low
//  XBGK_OE   out  1     1 = drive open-drain _XBGK low
//  GNT       out  NREQ  one-hot grant to the local masters
//  HIGHZ     out  1     1 = host bus owned; host-side drivers must tristate
//  TMO       out  1     one-cycle pulse on grant-wait timeout
//  STATE     out  3     current state code, for debug
// BEHAVIOUR
//  All inputs are sampled on posedge CLOCK. Outputs decode from registered state/GNT only (Moore); no combinational input->output path.
//  Reset/ENABLE=0: state=IDLE next edge; XBR_OE=0, XBGK_OE=0, GNT=0, HIGHZ=0, TMO=0, RR pointer=NREQ-1, timer=0.
//  Both take effect mid-transfer: no handshake completes and GNT drops at once. Local masters must tolerate this.
//  States and encodings: IDLE=0, REQ=1, ACCEPT=2, HELD=3, HANDOFF=4, REL=5; unused codes go to REL next cycle.
//  IDLE:    -> REQ when |REQ & _XBGK_IN & _XBR_IN & _XAS all high. Timer cleared.
//  REQ:     XBR_OE=1. Timer increments each cycle.
//           Priority: ~_XBGK_IN (another master won) -> IDLE;
//           else ~_XBG & _XAS -> ACCEPT;
//           else timer==TMO_MAX -> IDLE with TMO=1 for one cycle;
//           else stay.
//  ACCEPT:  XBR_OE=1, XBGK_OE=1. Winner is selected from REQ this cycle.
//           Winner found -> HELD with GNT=onehot(winner) on entry; REQ==0 -> REL.
//  HELD:    XBGK_OE=1, XBR_OE=0, HIGHZ=1, GNT held.
//           When REQ[owner] drops: ~_XBR_IN or no other REQ -> REL; else -> HANDOFF.
//  HANDOFF: XBGK_OE=1, HIGHZ=1, GNT=0 (one dead cycle). Re-select from REQ.
//           Winner -> HELD with the new GNT; none -> REL.
//  REL:     all drives off, GNT=0. -> IDLE when _XBGK_IN & _XAS both high; else stay.
//  Selection, fixed mode: lowest set index.
//  Selection, RR mode: first set index searching upward from ptr+1, modulo NREQ. ptr<=winner on every grant.
//  An owner that keeps REQ high is never pre-empted; the host reclaims the bus only at release.
//  Latency: REQ rising in IDLE -> XBR_OE one edge later. Host BG sampled low -> GNT valid two edges later (ACCEPT, HELD).
//  REQ pulses shorter than one cycle are not guaranteed to be seen.
// STRUCTURE
//  Shared header arb_defs.vh: state codes, STATE width, RR_MODE encodings; shared with the SDRAM-side arbiters.
//  Sub-module rr_pick: NREQ-wide rotating-base priority encoder.
//    Inputs: req, base, rr_en. Outputs: onehot, index, valid.
//    Pure combinational; instantiated once, used by both ACCEPT and HANDOFF.
// TESTING
//  1: NREQ=2, RR_MODE=0; REQ=01, host idle, _XBG low 3 cycles after XBR_OE.
//     -> REQ, ACCEPT, HELD; GNT=01, HIGHZ=1; REQ=00 -> REL then IDLE.
//  2: fixed mode; REQ=11 held, REQ[0] dropped while HELD.
//     -> HANDOFF, one cycle with GNT=00, then GNT=10; XBGK_OE never drops.
//  3: RR_MODE=1, NREQ=4; REQ=1111 with each owner releasing after 2 cycles.
//     -> grant order 0,1,2,3,0.
//  4: REQ=01, _XBG never asserted, TMO_MAX=5.
//     -> TMO pulse 6 cycles after entering REQ; back to IDLE; XBR_OE=0.
//  5: in REQ, _XBGK_IN pulled low by a third master -> IDLE next edge, no GNT.
//     Owner holding in HELD, _XBR_IN low, REQ=11 and owner drops -> REL, not HANDOFF.
//  6: RST=1 or ENABLE=0 asserted while HELD.
//     -> next edge: STATE=0, GNT=0, XBR_OE=XBGK_OE=HIGHZ=0.

Source files
------------

// File: rtl/bus_arbiter_multi_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_multi_pkg
// Definitions shared by the host-bus mastership arbiter and its selector.
// The SDRAM-side arbiters use the same state codes and selection-mode values.
//   STATE_W      width of the debug state code
//   RR_FIXED     selection mode: lowest requesting index wins
//   RR_ROUND     selection mode: round-robin starting after the last winner
//   arb_state_e  FSM state codes (IDLE=0 .. REL=5; codes 6/7 are unused)
//   idx_w()      index width needed to address n requesters (minimum 1)
// ----------------------------------------------------------------------------
package bus_arbiter_multi_pkg;

  localparam int STATE_W  = 3;
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ACCEPT  = 3'd2,
    ST_HELD    = 3'd3,
    ST_HANDOFF = 3'd4,
    ST_REL     = 3'd5
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_multi_rr_pick.sv
// ----------------------------------------------------------------------------
// bus_arbiter_multi_rr_pick
// Rotating-base priority encoder used to choose the next local bus master.
// Purely combinational.
//   req     in   NREQ   request vector
//   base    in   IDX_W  index of the previous winner (round-robin pointer)
//   rr_en   in   1      1 = search upward from base+1 (mod NREQ);
//                       0 = plain lowest-index-wins, base ignored
//   onehot  out  NREQ   one-hot winner, zero when nothing requests
//   index   out  IDX_W  binary winner index, zero when nothing requests
//   valid   out  1      a winner was found
// ----------------------------------------------------------------------------
module bus_arbiter_multi_rr_pick
  import bus_arbiter_multi_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] base,
  input  logic             rr_en,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  always_comb begin
    int start;
    logic [IDX_W-1:0] cand;
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    start  = rr_en ? ((int'(base) + 1) % NREQ) : 0;
    // Walk all NREQ positions once, starting at 'start' and wrapping; the
    // first requester found wins.
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((start + k) % NREQ);
      if (!valid && req[cand]) begin
        valid         = 1'b1;
        index         = cand;
        onehot[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_multi.sv
// ----------------------------------------------------------------------------
// bus_arbiter_multi
// 68000-style three-wire (BR/BG/BGACK) host-bus mastership arbiter for up to
// eight local masters. Requests the host bus, holds it with BGACK, grants it
// to one local master at a time, hands it between local masters without
// giving the host bus back, and releases it when the locals go idle or the
// host re-requests. Fixed-priority or round-robin selection; grant-wait
// timeout while waiting for host BG.
//
// Parameters
//   NREQ     number of local requesters (1..8)
//   RR_MODE  RR_FIXED (0) lowest index wins, RR_ROUND (1) round-robin
//   TMO_W    width of the grant-wait timer
//   TMO_MAX  REQ cycles without host BG before giving up (< 2**TMO_W)
//
// Ports
//   CLOCK     in   board clock, everything on posedge
//   RST       in   synchronous active-high reset
//   ENABLE    in   low forces IDLE and releases every drive
//   REQ       in   local requests, level-held until the master is done
//   _XAS      in   host address strobe (active low)
//   _XBG      in   host bus grant (active low)
//   _XBR_IN   in   sampled host bus-request line (active low)
//   _XBGK_IN  in   sampled host bus-grant-ack line (active low)
//   XBR_OE    out  drive open-drain _XBR low
//   XBGK_OE   out  drive open-drain _XBGK low
//   GNT       out  one-hot grant to the local masters
//   HIGHZ     out  host bus owned; host-side drivers must tristate
//   TMO       out  one-cycle pulse on grant-wait timeout
//   STATE     out  current state code (debug)
//
// All outputs decode from registered state / grant / timeout flags only.
// ----------------------------------------------------------------------------
module bus_arbiter_multi
  import bus_arbiter_multi_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR_MODE = RR_FIXED,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic               CLOCK,
  input  logic               RST,
  input  logic               ENABLE,
  input  logic [NREQ-1:0]    REQ,
  input  logic               _XAS,
  input  logic               _XBG,
  input  logic               _XBR_IN,
  input  logic               _XBGK_IN,
  output logic               XBR_OE,
  output logic               XBGK_OE,
  output logic [NREQ-1:0]    GNT,
  output logic               HIGHZ,
  output logic               TMO,
  output logic [STATE_W-1:0] STATE
);

  localparam int               IDX_W     = idx_w(NREQ);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_MAX);
  localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NREQ - 1);
  localparam logic             RR_EN     = (RR_MODE == RR_ROUND);

  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("bus_arbiter_multi: NREQ must be 1..8");
  end
  if (TMO_MAX >= (2 ** TMO_W)) begin : g_bad_tmo
    $error("bus_arbiter_multi: TMO_MAX does not fit in TMO_W bits");
  end

  arb_state_e       state, state_nx;
  logic [TMO_W-1:0] timer, timer_nx;
  logic [NREQ-1:0]  gnt, gnt_nx;
  // Last winner; doubles as the round-robin pointer. Survives release so
  // the rotation continues across host-bus tenures.
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic             tmo, tmo_nx;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_index;
  logic             pick_valid;

  logic             owner_done;
  logic             others_waiting;

  // One selector serves both ACCEPT and HANDOFF; in HANDOFF the previous
  // owner has already dropped its request, so it cannot win again here.
  bus_arbiter_multi_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (REQ),
    .base   (ptr),
    .rr_en  (RR_EN),
    .onehot (pick_onehot),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  assign owner_done     = ~|(REQ & gnt);
  assign others_waiting = |(REQ & ~gnt);

  // State register. RST and ENABLE=0 act identically and immediately,
  // abandoning any handshake in progress.
  always_ff @(posedge CLOCK) begin
    if (RST || !ENABLE) begin
      state <= ST_IDLE;
      timer <= '0;
      gnt   <= '0;
      ptr   <= PTR_INIT;
      tmo   <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      gnt   <= gnt_nx;
      ptr   <= ptr_nx;
      tmo   <= tmo_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    timer_nx = '0;
    gnt_nx   = '0;
    ptr_nx   = ptr;
    tmo_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Only ask when the host bus is completely quiet.
        if (|REQ && _XBGK_IN && _XBR_IN && _XAS) begin
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        timer_nx = timer + 1'b1;
        if (!_XBGK_IN) begin
          // Another master took the bus first; back off.
          state_nx = ST_IDLE;
        end else if (!_XBG && _XAS) begin
          state_nx = ST_ACCEPT;
        end else if (timer == TMO_LIMIT) begin
          state_nx = ST_IDLE;
          tmo_nx   = 1'b1;
        end
      end
      ST_ACCEPT, ST_HANDOFF: begin
        if (pick_valid) begin
          state_nx = ST_HELD;
          gnt_nx   = pick_onehot;
          ptr_nx   = pick_index;
        end else begin
          state_nx = ST_REL;
        end
      end
      ST_HELD: begin
        gnt_nx = gnt;
        if (owner_done) begin
          gnt_nx = '0;
          // A pending host request wins over further local handoffs.
          if (!_XBR_IN || !others_waiting) begin
            state_nx = ST_REL;
          end else begin
            state_nx = ST_HANDOFF;
          end
        end
      end
      ST_REL: begin
        if (_XBGK_IN && _XAS) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_REL;
      end
    endcase
  end

  // Output decode (Moore).
  always_comb begin
    XBR_OE  = (state == ST_REQ) || (state == ST_ACCEPT);
    XBGK_OE = (state == ST_ACCEPT) || (state == ST_HELD) || (state == ST_HANDOFF);
    HIGHZ   = (state == ST_HELD) || (state == ST_HANDOFF);
    GNT     = gnt;
    TMO     = tmo;
    STATE   = state;
  end

endmodule
